// File: rtl/qam_pkg.sv
// Shared definitions for the QAM symbol path: modulation order codes,
// per-order symbol geometry and the scheduler state encoding.
package qam_pkg;

    localparam logic [2:0] QAM_BPSK = 3'd0;
    localparam logic [2:0] QAM_QPSK = 3'd1;
    localparam logic [2:0] QAM_16   = 3'd2;

    localparam int WORD_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sched_state_e;

    // Bits carried by one symbol of the given order (illegal orders map to 1).
    function automatic logic [2:0] bits_per_symbol(input logic [2:0] order);
        logic [2:0] bps;
        case (order)
            QAM_BPSK: bps = 3'd1;
            QAM_QPSK: bps = 3'd2;
            QAM_16:   bps = 3'd4;
            default:  bps = 3'd1;
        endcase
        return bps;
    endfunction

    // Symbols needed to carry one 32-bit word at the given order.
    function automatic logic [5:0] symbols_per_word(input logic [2:0] order);
        logic [5:0] spw;
        case (order)
            QAM_BPSK: spw = 6'd32;
            QAM_QPSK: spw = 6'd16;
            QAM_16:   spw = 6'd8;
            default:  spw = 6'd32;
        endcase
        return spw;
    endfunction

    // True only for the orders the mapper bank implements.
    function automatic logic order_legal(input logic [2:0] order);
        logic ok;
        case (order)
            QAM_BPSK: ok = 1'b1;
            QAM_QPSK: ok = 1'b1;
            QAM_16:   ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/qam_symbol_scheduler_if.sv
// Word-request side (framers) and symbol side (mapper) of the scheduler.
// The master modport is the scheduler's view; slave is the surrounding logic.
interface qam_symbol_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) ();

    logic [NUM_CH-1:0]    s_valid;
    logic [NUM_CH-1:0]    s_ready;
    logic [NUM_CH*32-1:0] s_data;
    logic [NUM_CH*3-1:0]  s_qam;

    logic                 m_valid;
    logic                 m_ready;
    logic [3:0]           m_symbol;
    logic [2:0]           m_qam;
    logic [CH_W-1:0]      m_chan;
    logic                 m_last;

    modport master (
        input  s_valid, s_data, s_qam, m_ready,
        output s_ready, m_valid, m_symbol, m_qam, m_chan, m_last
    );

    modport slave (
        output s_valid, s_data, s_qam, m_ready,
        input  s_ready, m_valid, m_symbol, m_qam, m_chan, m_last
    );

endinterface

// File: rtl/qam_symbol_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// ptr, wrapping modulo NUM_CH. The pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    // Channel index reached by stepping off positions past base, wrapped.
    function automatic int wrap_idx(input logic [CH_W-1:0] base, input int off);
        return (int'(base) + off) % NUM_CH;
    endfunction

    // Scan from ptr upward; the first requester seen wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!any && req[wrap_idx(ptr, i)]) begin
                any                  = 1'b1;
                gnt[wrap_idx(ptr, i)] = 1'b1;
                gnt_idx              = CH_W'(wrap_idx(ptr, i));
            end else begin
                // an earlier position already won; keep it
            end
        end
    end

endmodule

// File: rtl/qam_symbol_scheduler.sv
// Shares one QAM mapper between NUM_CH word streams: grants one 32-bit word
// at a time round-robin, then serialises it LSB-first into symbols of the
// order latched at grant time.
module qam_symbol_scheduler
    import qam_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    qam_symbol_scheduler_if.master  bus,
    output logic                    busy,
    output logic                    err
);

    sched_state_e        state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [4:0]          cnt_q, cnt_d;
    logic [2:0]          qam_q, qam_d;
    logic [CH_W-1:0]     chan_q, chan_d;
    logic                err_q, err_d;

    logic [NUM_CH-1:0]   gnt_s;
    logic [CH_W-1:0]     gnt_idx_s;
    logic                any_s;
    logic [WORD_W-1:0]   g_data_s;
    logic [2:0]          g_qam_s;
    logic [2:0]          bps_s;
    logic [5:0]          spw_s;
    logic                last_s;
    logic [3:0]          sym_s;

    // Channel after c, wrapping at NUM_CH (NUM_CH need not be a power of two).
    function automatic logic [CH_W-1:0] next_ptr(input logic [CH_W-1:0] c);
        return CH_W'((int'(c) + 1) % NUM_CH);
    endfunction

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (bus.s_valid),
        .ptr     (ptr_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .any     (any_s)
    );

    assign g_data_s = bus.s_data[int'(gnt_idx_s)*32 +: 32];
    assign g_qam_s  = bus.s_qam[int'(gnt_idx_s)*3 +: 3];
    assign bps_s    = bits_per_symbol(qam_q);
    assign spw_s    = symbols_per_word(qam_q);
    assign last_s   = (cnt_q == 5'(spw_s - 6'd1));

    // Current symbol: low bps bits of the shifter, zero-extended to 4 bits.
    always_comb begin
        sym_s = 4'b0000;
        case (qam_q)
            QAM_BPSK: sym_s = {3'b000, shift_q[0]};
            QAM_QPSK: sym_s = {2'b00, shift_q[1:0]};
            QAM_16:   sym_s = shift_q[3:0];
            default:  sym_s = 4'b0000;
        endcase
    end

    // Next-state logic: grant/latch a word in IDLE, step the shifter in SEND.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        qam_d   = qam_q;
        chan_d  = chan_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    shift_d = g_data_s;
                    qam_d   = g_qam_s;
                    chan_d  = gnt_idx_s;
                    cnt_d   = 5'd0;
                    if (order_legal(g_qam_s)) begin
                        state_d = ST_SEND;
                    end else begin
                        // word is consumed and discarded; move past its channel
                        err_d = 1'b1;
                        ptr_d = next_ptr(gnt_idx_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.m_ready) begin
                    shift_d = shift_q >> bps_s;
                    cnt_d   = cnt_q + 5'd1;
                    if (last_s) begin
                        state_d = ST_IDLE;
                        ptr_d   = next_ptr(chan_q);
                    end else begin
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            shift_q <= '0;
            cnt_q   <= 5'd0;
            qam_q   <= 3'd0;
            chan_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            qam_q   <= qam_d;
            chan_q  <= chan_d;
            err_q   <= err_d;
        end
    end

    // Symbol-side outputs come straight from registers and are zero outside SEND.
    always_comb begin
        bus.m_valid  = 1'b0;
        bus.m_symbol = 4'b0000;
        bus.m_qam    = 3'd0;
        bus.m_chan   = '0;
        bus.m_last   = 1'b0;
        if (state_q == ST_SEND) begin
            bus.m_valid  = 1'b1;
            bus.m_symbol = sym_s;
            bus.m_qam    = qam_q;
            bus.m_chan   = chan_q;
            bus.m_last   = last_s;
        end else begin
            bus.m_valid  = 1'b0;
        end
    end

    // Word accept strobe: only in IDLE, and held off while reset is asserted.
    always_comb begin
        bus.s_ready = '0;
        if (rst && (state_q == ST_IDLE)) begin
            bus.s_ready = gnt_s;
        end else begin
            bus.s_ready = '0;
        end
    end

    assign busy = (state_q == ST_SEND);
    assign err  = err_q;

endmodule

// File: doc/qam_symbol_scheduler.md
# qam_symbol_scheduler

Round-robin scheduler that shares one QAM symbol mapper between NUM_CH word-stream requesters. It accepts one 32-bit word at a time from the granted channel, latches that channel's modulation order, and serialises the word LSB-first into symbols with per-symbol valid/ready backpressure. The modulation order stays fixed for the whole word. It sits between the per-channel framers and the qam_2/qam_4/qam_16 mapper bank, and replaces the per-word bit counting that the mapper top previously did inline.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..8)
- CH_W, $clog2(NUM_CH): channel index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-low**
- s_valid  in  NUM_CH  per-channel word available
- s_ready  out  NUM_CH  per-channel word accepted (one-hot or zero)
- s_data  in  NUM_CH*32  channel c word at [32c+31:32c]
- s_qam  in  NUM_CH*3  channel c order at [3c+2:3c]; 0=BPSK, 1=QPSK, 2=16QAM, 3..7 illegal
- m_valid  out  1  symbol valid to mapper
- m_ready  in  1  mapper accepts symbol
- m_symbol  out  4  symbol bits, LSB-aligned, unused upper bits zero
- m_qam  out  3  order of the current symbol
- m_chan  out  CH_W  source channel of the current symbol
- m_last  out  1  final symbol of the word
- busy  out  1  high in SEND
- err  out  1  one-cycle pulse when a word with illegal order is dropped

## Operation
- Bits per symbol (bps) by order: 0→1, 1→2, 2→4. Symbols per word (spw): 32, 16, 8.
- FSM states: IDLE and SEND.
- IDLE:
  - The round-robin arbiter selects the first c with s_valid[c], searching from ptr upward and wrapping modulo NUM_CH.
  - s_ready[g] is driven combinationally high for that c only; the word is consumed in the same cycle.
  - The word goes into shift_reg, the order into qam_r, g into chan_r, and sym_cnt is cleared.
  - Legal order: go to SEND.
  - Illegal order: stay in IDLE, pulse err next cycle, set ptr=g+1 mod NUM_CH. The word is dropped.
  - No s_valid set: s_ready is all zero and nothing changes.
- SEND:
  - m_valid=1; m_symbol=shift_reg[bps-1:0] zero-extended.
  - m_qam=qam_r, m_chan=chan_r, m_last=(sym_cnt==spw-1).
  - On m_valid&m_ready: shift_reg >>= bps and sym_cnt++.
  - If m_last was set, go to IDLE and set ptr=chan_r+1 mod NUM_CH.
- s_ready is all zero in SEND, whatever s_valid or s_qam do. Changes to s_qam mid-word have no effect.
- m_symbol, m_qam, m_chan and m_last stay stable while m_valid&!m_ready.
- sym_cnt is 5 bits. Its maximum value is 31, reached only for BPSK.

## Timing
- Reset (rst=0 at a clk edge):
  - state=IDLE, ptr=0, shift_reg=0, sym_cnt=0, qam_r=0, chan_r=0.
  - Outputs: m_valid=0, m_last=0, busy=0, err=0, m_symbol=0, m_qam=0, m_chan=0, s_ready=0 (forced to zero while rst=0).
- Reset mid-word aborts the word with no further symbols. The first post-reset grant starts the search from channel 0.
- Latency:
  - Word accepted in cycle N; the first symbol has m_valid high in cycle N+1.
  - Minimum word duration with m_ready held high: spw cycles in SEND plus 1 IDLE cycle. BPSK=33, QPSK=17, 16QAM=9.
- When m_last is accepted, the next cycle is IDLE. Back-to-back words therefore always have exactly one idle cycle.
- err rises the cycle after the illegal word's s_ready cycle and lasts one cycle.
- If only one channel is requesting, it is granted every IDLE cycle it is valid. Starvation is bounded by NUM_CH-1 words.

## Structure
- Shared package qam_pkg holds:
  - order constants QAM_BPSK=3'd0, QAM_QPSK=3'd1, QAM_16=3'd2
  - function bits_per_symbol(order)
  - function symbols_per_word(order)
  - function order_legal(order)
  - state encoding for IDLE/SEND
- Sub-module rr_arbiter(NUM_CH): inputs req and ptr, outputs one-hot gnt, gnt_idx and any. It is purely combinational. The pointer register lives in the scheduler.

## Test plan
- Reset, then ch0 s_valid with data 0xA5A5_0F0F and qam=2:
  - s_ready[0] pulses once.
  - 8 symbols F,0,F,0,5,A,5,A follow in consecutive cycles.
  - m_last is high on the 8th; busy=1 for those 8 cycles.
- Ch1, qam=0, data 0x0000_0001, m_ready toggled 1,0,1,0:
  - 32 symbols, the first =1 and the rest =0.
  - Outputs hold during stalls; m_last only on symbol 32.
- All 4 channels valid, qam=1:
  - grant order 0,1,2,3,0, each word is 16 symbols, m_chan matches the grant.
  - s_ready never asserts in SEND.
- Ch2 qam=5:
  - s_ready[2] pulses, err pulses next cycle, no m_valid.
  - The next grant goes to ch3 if it is requesting.
- Reset mid-word (after 3 of 8 16QAM symbols):
  - m_valid=0 and all outputs zero the cycle after rst low.
  - After release, ch0 is granted first.
- s_qam of the granted channel changed mid-word from 2 to 0:
  - m_qam stays 2 and exactly 8 symbols are emitted.
